// File: rtl/fabric_output_arbiter.sv
// Frame-level round-robin arbiter that shares one egress TxFifoBus among NUM_PORTS fabric requesters.
// Define FABRIC_ARB_PRIO_EN to give port 0 (management/CPU) strict priority during arbitration.
module fabric_output_arbiter #(
    parameter int NUM_PORTS     = 14,
    parameter int GRANT_TIMEOUT = 16,
    parameter int DATA_W        = 64,
    parameter int BV_W          = 4,
    parameter int VLAN_W        = 12,
    parameter int ETYPE_W       = 16,
    localparam int BUS_W        = 1 + ETYPE_W + VLAN_W + BV_W + DATA_W,
    localparam int PTR_W        = $clog2(NUM_PORTS)
) (
    input  logic                              fabric_clk,
    input  logic                              fabric_rst_n,
    input  logic [NUM_PORTS-1:0]              req,
    input  logic [NUM_PORTS-1:0][BUS_W-1:0]   in_bus,
    output logic [NUM_PORTS-1:0]              grant,
    input  logic                              fabric_ready,
    output logic [BUS_W-1:0]                  out_bus,
    output logic [PTR_W-1:0]                  cur_port,
    output logic                              busy,
    output logic                              timeout_pulse
);

    // TxFifoBus layout, MSB first: {valid, ethertype, vlan, bytes_valid, data}
    localparam int VALID_BIT = BUS_W - 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;
    localparam logic [1:0] ST_GAP    = 2'd3;

    localparam int              CNT_W    = $clog2(GRANT_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(GRANT_TIMEOUT - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_PORTS - 1);

    // Reset asserts asynchronously but is released only after two clean clock edges.
    logic [1:0] rst_sync_reg;
    logic       arb_rst_n;

    always_ff @(posedge fabric_clk or negedge fabric_rst_n) begin
        if (!fabric_rst_n) begin
            rst_sync_reg <= 2'b00;
        end else begin
            rst_sync_reg <= {rst_sync_reg[0], 1'b1};
        end
    end

    assign arb_rst_n = rst_sync_reg[1];

    logic [1:0]               state_reg, state_next;
    logic [NUM_PORTS-1:0]     grant_reg, grant_next;
    logic [BUS_W-1:0]         out_bus_reg, out_bus_next;
    logic [PTR_W-1:0]         cur_port_reg, cur_port_next;
    logic [PTR_W-1:0]         rr_ptr_reg, rr_ptr_next;
    logic [CNT_W-1:0]         tmo_cnt_reg, tmo_cnt_next;
    logic                     tmo_pulse_reg, tmo_pulse_next;

    logic [NUM_PORTS-1:0]     in_valid;
    logic [BUS_W-1:0]         sel_bus;
    logic                     sel_valid;
    logic                     sel_req;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_valid
            assign in_valid[gi] = in_bus[gi][VALID_BIT];
        end
    endgenerate

    // Only the current grantee's bus is ever looked at.
    assign sel_bus   = in_bus[cur_port_reg];
    assign sel_valid = in_valid[cur_port_reg];
    assign sel_req   = req[cur_port_reg];

    logic [PTR_W-1:0] rr_winner;
    logic             rr_found;
    logic [PTR_W-1:0] idx_v;

    // Scan from the highest offset down so the last hit is the first requester after rr_ptr.
    always_comb begin
        rr_winner = '0;
        rr_found  = 1'b0;
        idx_v     = '0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            idx_v = PTR_W'((int'(rr_ptr_reg) + k) % NUM_PORTS);
            if (req[idx_v]) begin
                rr_winner = idx_v;
                rr_found  = 1'b1;
            end
        end
    end

    logic [PTR_W-1:0] arb_winner;
    logic             arb_found;
    logic             arb_upd_rr;

`ifdef FABRIC_ARB_PRIO_EN
    // Port 0 wins outright and leaves the round-robin pointer untouched.
    always_comb begin
        if (req[0]) begin
            arb_winner = '0;
            arb_found  = 1'b1;
            arb_upd_rr = 1'b0;
        end else begin
            arb_winner = rr_winner;
            arb_found  = rr_found;
            arb_upd_rr = 1'b1;
        end
    end
`else
    always_comb begin
        arb_winner = rr_winner;
        arb_found  = rr_found;
        arb_upd_rr = 1'b1;
    end
`endif

    always_comb begin
        state_next     = state_reg;
        grant_next     = grant_reg;
        out_bus_next   = '0;
        cur_port_next  = cur_port_reg;
        rr_ptr_next    = rr_ptr_reg;
        tmo_cnt_next   = tmo_cnt_reg;
        tmo_pulse_next = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                grant_next = '0;
                if (fabric_ready && arb_found) begin
                    grant_next    = {{(NUM_PORTS-1){1'b0}}, 1'b1} << arb_winner;
                    cur_port_next = arb_winner;
                    if (arb_upd_rr) begin
                        rr_ptr_next = arb_winner;
                    end
                    tmo_cnt_next  = '0;
                    state_next    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A valid beat takes precedence over a coincident timeout or request drop.
                if (sel_valid) begin
                    out_bus_next = sel_bus;
                    state_next   = ST_ACTIVE;
                end else if (!sel_req) begin
                    grant_next = '0;
                    state_next = ST_GAP;
                end else if (tmo_cnt_reg == TMO_LAST) begin
                    grant_next     = '0;
                    tmo_pulse_next = 1'b1;
                    state_next     = ST_GAP;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (sel_valid) begin
                    out_bus_next = sel_bus;
                end else begin
                    grant_next = '0;
                    state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                grant_next = '0;
                state_next = ST_IDLE;
            end
            default: begin
                grant_next = '0;
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge fabric_clk or negedge arb_rst_n) begin
        if (!arb_rst_n) begin
            state_reg     <= ST_IDLE;
            grant_reg     <= '0;
            out_bus_reg   <= '0;
            cur_port_reg  <= '0;
            rr_ptr_reg    <= PTR_LAST;
            tmo_cnt_reg   <= '0;
            tmo_pulse_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            grant_reg     <= grant_next;
            out_bus_reg   <= out_bus_next;
            cur_port_reg  <= cur_port_next;
            rr_ptr_reg    <= rr_ptr_next;
            tmo_cnt_reg   <= tmo_cnt_next;
            tmo_pulse_reg <= tmo_pulse_next;
        end
    end

    assign grant         = grant_reg;
    assign out_bus       = out_bus_reg;
    assign cur_port      = cur_port_reg;
    assign busy          = (state_reg != ST_IDLE);
    assign timeout_pulse = tmo_pulse_reg;

endmodule

// File: tb/tb_fabric_output_arbiter.sv
// Scoreboard bench for fabric_output_arbiter: beats are queued when driven and matched when out_bus shows them.
`timescale 1ns/1ps
module tb_fabric_output_arbiter;

    localparam int NUM_PORTS     = 14;
    localparam int GRANT_TIMEOUT = 16;
    localparam int DATA_W        = 64;
    localparam int BV_W          = 4;
    localparam int VLAN_W        = 12;
    localparam int ETYPE_W       = 16;
    localparam int BUS_W         = 1 + ETYPE_W + VLAN_W + BV_W + DATA_W;
    localparam int PTR_W         = $clog2(NUM_PORTS);

    logic                            fabric_clk = 1'b0;
    logic                            fabric_rst_n = 1'b0;
    logic [NUM_PORTS-1:0]            req = '0;
    logic [NUM_PORTS-1:0][BUS_W-1:0] in_bus = '0;
    logic [NUM_PORTS-1:0]            grant;
    logic                            fabric_ready = 1'b1;
    logic [BUS_W-1:0]                out_bus;
    logic [PTR_W-1:0]                cur_port;
    logic                            busy;
    logic                            timeout_pulse;

    fabric_output_arbiter #(
        .NUM_PORTS     (NUM_PORTS),
        .GRANT_TIMEOUT (GRANT_TIMEOUT),
        .DATA_W        (DATA_W),
        .BV_W          (BV_W),
        .VLAN_W        (VLAN_W),
        .ETYPE_W       (ETYPE_W)
    ) dut (
        .fabric_clk    (fabric_clk),
        .fabric_rst_n  (fabric_rst_n),
        .req           (req),
        .in_bus        (in_bus),
        .grant         (grant),
        .fabric_ready  (fabric_ready),
        .out_bus       (out_bus),
        .cur_port      (cur_port),
        .busy          (busy),
        .timeout_pulse (timeout_pulse)
    );

    always #5 fabric_clk = ~fabric_clk;

    int cyc = 0;
    initial forever begin
        @(posedge fabric_clk);
        cyc++;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [BUS_W-1:0] bus;
        int               cyc;
    } exp_t;

    exp_t sb_q[$];

    function automatic logic [BUS_W-1:0] make_beat(input logic [63:0] d, input logic [3:0] bv,
                                                   input logic [11:0] vlan, input logic [15:0] et);
        return {1'b1, et, vlan, bv, d};
    endfunction

    // Output monitor: pops one expected beat per valid cycle and checks inter-frame spacing.
    int gap_cnt    = 0;
    bit seen_frame = 1'b0;
    bit prev_valid = 1'b0;
    initial forever begin
        @(negedge fabric_clk);
        if (!fabric_rst_n) begin
            gap_cnt    = 0;
            seen_frame = 1'b0;
            prev_valid = 1'b0;
        end else if (out_bus[BUS_W-1]) begin
            if (!prev_valid && seen_frame) begin
                chk("gap_ge2", 128'(gap_cnt >= 2), 128'(1));
            end
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_beat", 128'(out_bus), 128'(0));
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("beat", 128'(out_bus), 128'(e.bus));
                chk("beat_latency", 128'(cyc), 128'(e.cyc));
            end
            prev_valid = 1'b1;
            seen_frame = 1'b1;
            gap_cnt    = 0;
        end else begin
            chk("idle_bus_zero", 128'(out_bus), 128'(0));
            prev_valid = 1'b0;
            gap_cnt++;
        end
    end

    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge fabric_clk);
            if (grant != '0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("grant_wait_expired", 128'(0), 128'(1));
    endtask

    task automatic run_frame(input int port, input int nbeats, input logic [63:0] dbase,
                             input logic [3:0] last_bv, input int mid_req, input bit granted,
                             input bit drop_req);
        bit                   ok;
        logic [BUS_W-1:0]     b;
        logic [NUM_PORTS-1:0] oh;
        exp_t                 e;
        ok = granted;
        if (!granted) wait_grant(ok);
        if (!ok) return;
        oh = NUM_PORTS'(1) << port;
        chk($sformatf("grant_p%0d", port), 128'(grant), 128'(oh));
        chk($sformatf("cur_port_p%0d", port), 128'(cur_port), 128'(port));
        chk("busy_granted", 128'(busy), 128'(1));
        for (int k = 0; k < nbeats; k++) begin
            b = make_beat(dbase + 64'(k), (k == nbeats - 1) ? last_bv : 4'd8,
                          12'(port), 16'h0800 + 16'(k));
            in_bus[PTR_W'(port)] = b;
            e.bus = b;
            e.cyc = cyc + 1;
            sb_q.push_back(e);
            if (mid_req >= 0 && k == 1) req[PTR_W'(mid_req)] = 1'b1;
            @(negedge fabric_clk);
            chk("grant_hold", 128'(grant), 128'(oh));
        end
        in_bus[PTR_W'(port)] = '0;
        if (drop_req) req[PTR_W'(port)] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int k;
        logic [BUS_W-1:0] b;
        exp_t e;

        // Reset state, with every port requesting
        req = '1;
        fabric_ready = 1'b1;
        repeat (3) @(negedge fabric_clk);
        chk("rst_grant", 128'(grant), 128'(0));
        chk("rst_out_bus", 128'(out_bus), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_timeout", 128'(timeout_pulse), 128'(0));
        chk("rst_cur_port", 128'(cur_port), 128'(0));
        fabric_rst_n = 1'b1;

        // Round robin through all ports, 3-beat frames
        for (int p = 0; p < NUM_PORTS; p++) begin
            run_frame(p, 3, 64'hA000_0000_0000_0000 + (64'(p) << 8), 4'd4, -1, 1'b0, 1'b0);
        end
        req = '0;

        // No grant while the FIFO has no room
        fabric_ready = 1'b0;
        req = NUM_PORTS'(1) << 5;
        repeat (3) @(negedge fabric_clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge fabric_clk);
            chk("noready_grant", 128'(grant), 128'(0));
            chk("noready_busy", 128'(busy), 128'(0));
        end
        fabric_ready = 1'b1;
        @(negedge fabric_clk);
        run_frame(5, 2, 64'h5555_0000_0000_0000, 4'd2, -1, 1'b1, 1'b1);

        // Port 3 granted but silent: revoked by timeout
        req = NUM_PORTS'(1) << 3;
        wait_grant(ok);
        chk("tmo_grant_p3", 128'(grant), 128'(NUM_PORTS'(1) << 3));
        for (k = 1; k <= 40; k++) begin
            @(negedge fabric_clk);
            if (timeout_pulse) break;
        end
        chk("tmo_latency", 128'(k), 128'(GRANT_TIMEOUT));
        chk("tmo_grant_cleared", 128'(grant), 128'(0));
        chk("tmo_busy_gap", 128'(busy), 128'(1));
        @(negedge fabric_clk);
        chk("tmo_pulse_single", 128'(timeout_pulse), 128'(0));
        req = (NUM_PORTS'(1) << 2) | (NUM_PORTS'(1) << 3) | (NUM_PORTS'(1) << 4);
        run_frame(4, 1, 64'h4444_0000_0000_0000, 4'd1, -1, 1'b0, 1'b1);
        req = '0;

        // Long frame on port 7 with a competing request arriving mid-frame
        req = NUM_PORTS'(1) << 7;
        run_frame(7, 6, 64'hDEADBEEF_CAFEF00D, 4'd5, 2, 1'b0, 1'b1);

        // Port 2 wins next; reset lands in the middle of its frame
        wait_grant(ok);
        chk("grant_p2_after7", 128'(grant), 128'(NUM_PORTS'(1) << 2));
        for (int i = 0; i < 2; i++) begin
            b = make_beat(64'h2222_0000_0000_0000 + 64'(i), 4'd8, 12'd2, 16'h86DD);
            in_bus[PTR_W'(2)] = b;
            e.bus = b;
            e.cyc = cyc + 1;
            sb_q.push_back(e);
            @(negedge fabric_clk);
        end
        #2;
        fabric_rst_n = 1'b0;
        #1;
        chk("async_rst_grant", 128'(grant), 128'(0));
        chk("async_rst_out_bus", 128'(out_bus), 128'(0));
        chk("async_rst_busy", 128'(busy), 128'(0));
        in_bus = '0;
        req = '0;
        sb_q.delete();
        repeat (2) @(negedge fabric_clk);
        fabric_rst_n = 1'b1;

        // Ports 0 and 9 requesting continuously
        req = (NUM_PORTS'(1) << 0) | (NUM_PORTS'(1) << 9);
        for (int f = 0; f < 4; f++) begin
            int exp_p;
`ifdef FABRIC_ARB_PRIO_EN
            exp_p = 0;
`else
            exp_p = (f % 2 == 0) ? 0 : 9;
`endif
            run_frame(exp_p, 2, 64'h9000_0000_0000_0000 + (64'(f) << 16), 4'd3, -1, 1'b0, 1'b0);
        end
        req = '0;

        repeat (10) @(negedge fabric_clk);
        chk("sb_empty", 128'(sb_q.size()), 128'(0));
        chk("final_busy", 128'(busy), 128'(0));
        chk("final_grant", 128'(grant), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
